// File: rtl/mc_trace_buffer.sv
// mc_trace_buffer
//   Instruction-trace and performance monitor for the multicycle MIPS CPU.
//   It watches the CPU debug outputs and records one {pc, ir} entry for each
//   fetched instruction in a drainable FIFO. It also keeps cycle and
//   instruction counters and flags a self-loop halt.
//
// Ports
//   clk       CPU clock; all state changes on the rising edge
//   clr       asynchronous active-high reset
//   en        capture/count enable
//   q         CPU control state
//   pc, ir    CPU program counter and instruction register
//   rd_en     pop request
//   rd_pc     popped pc (registered)
//   rd_ir     popped instruction (registered)
//   rd_valid  rd_pc/rd_ir hold a freshly popped entry this cycle
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   count     FIFO occupancy
//   overflow  sticky; a capture was dropped because the FIFO was full
//   cycles    saturating count of enabled, non-halted cycles
//   instrs    saturating count of capture events, dropped ones included
//   halted    sticky; self-loop detected
module mc_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int STATE_W     = 3,
  parameter int FETCH_STATE = 0,
  parameter int HALT_CNT    = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     en,
  input  logic [STATE_W-1:0]       q,
  input  logic [31:0]              pc,
  input  logic [31:0]              ir,
  input  logic                     rd_en,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_ir,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [31:0]              cycles,
  output logic [31:0]              instrs,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(HALT_CNT + 1);

  localparam logic [STATE_W-1:0] FETCH     = STATE_W'(FETCH_STATE);
  localparam logic [SW-1:0]      SAME_MAX  = SW'(HALT_CNT);
  localparam logic [SW-1:0]      SAME_TRIP = SW'(HALT_CNT - 1);
  localparam logic [CW-1:0]      CNT_FULL  = CW'(DEPTH);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [SW-1:0] sat_inc_same(input logic [SW-1:0] v);
    return (v >= SAME_MAX) ? SAME_MAX : v + SW'(1);
  endfunction

  logic [63:0]        mem [DEPTH];
  logic [STATE_W-1:0] q_prev;
  logic [31:0]        pc_f;
  logic [31:0]        last_pc;
  logic [SW-1:0]      same_cnt;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;

  logic               capture;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               same_pc;
  logic               halt_hit;
  logic [CW-1:0]      count_nxt;

  // Event decode: a capture fires on the first cycle after leaving fetch,
  // so a run of fetch cycles yields a single capture of the last fetch pc.
  always_comb begin
    capture   = (q_prev == FETCH) && (q != FETCH) && en && !halted;
    pop       = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push at full is kept.
    push_ok   = capture && (!full || pop);
    drop      = capture && full && !pop;
    same_pc   = (pc_f == last_pc);
    halt_hit  = capture && same_pc && (same_cnt >= SAME_TRIP);
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= {pc_f, ir};
    end
  end

  // Fetch tracking, FIFO control, counters and halt detection.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_prev   <= '0;
      pc_f     <= '0;
      last_pc  <= '0;
      same_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_ir    <= '0;
      cycles   <= '0;
      instrs   <= '0;
      halted   <= 1'b0;
    end else begin
      q_prev <= q;
      if (q == FETCH) begin
        pc_f <= pc;
      end

      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      rd_valid <= pop;
      if (pop) begin
        rd_pc <= mem[rptr][63:32];
        rd_ir <= mem[rptr][31:0];
        rptr  <= rptr + AW'(1);
      end

      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_FULL);

      if (en && !halted) begin
        cycles <= sat_inc32(cycles);
      end

      if (capture) begin
        instrs  <= sat_inc32(instrs);
        last_pc <= pc_f;
        same_cnt <= same_pc ? sat_inc_same(same_cnt) : '0;
      end
      if (halt_hit) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_trace_buffer.sv
module tb_mc_trace_buffer;

  localparam int DEPTH    = 4;
  localparam int STATE_W  = 3;
  localparam int FS       = 0;
  localparam int HALT_CNT = 3;

  logic                   clk = 1'b0;
  logic                   clr = 1'b1;
  logic                   en = 1'b0;
  logic [STATE_W-1:0]     q = '0;
  logic [31:0]            pc = '0;
  logic [31:0]            ir = '0;
  logic                   rd_en = 1'b0;
  logic [31:0]            rd_pc;
  logic [31:0]            rd_ir;
  logic                   rd_valid;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic [31:0]            cycles;
  logic [31:0]            instrs;
  logic                   halted;

  mc_trace_buffer #(
    .DEPTH(DEPTH), .STATE_W(STATE_W), .FETCH_STATE(FS), .HALT_CNT(HALT_CNT)
  ) dut (
    .clk(clk), .clr(clr), .en(en), .q(q), .pc(pc), .ir(ir), .rd_en(rd_en),
    .rd_pc(rd_pc), .rd_ir(rd_ir), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .cycles(cycles),
    .instrs(instrs), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: trace as a queue of {pc, ir}, counters as plain numbers.
  int          m_qprev;
  logic [31:0] m_pcf;
  logic [63:0] m_fifo[$];
  bit          m_ovf;
  longint      m_cycles;
  longint      m_instrs;
  bit          m_halted;
  logic [31:0] m_last;
  int          m_same;
  bit          m_rdv;
  logic [31:0] m_rdpc;
  logic [31:0] m_rdir;

  task automatic model_reset();
    m_qprev = 0; m_pcf = '0; m_fifo.delete(); m_ovf = 0;
    m_cycles = 0; m_instrs = 0; m_halted = 0; m_last = '0; m_same = 0;
    m_rdv = 0; m_rdpc = '0; m_rdir = '0;
  endtask

  task automatic model_step();
    bit capt;
    bit popn;
    capt = (m_qprev == FS) && (int'(q) != FS) && en && !m_halted;
    popn = rd_en && (m_fifo.size() != 0);
    m_rdv = popn;
    if (popn) {m_rdpc, m_rdir} = m_fifo.pop_front();
    if (en && !m_halted && m_cycles < 64'hFFFF_FFFF) m_cycles++;
    if (capt) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back({m_pcf, ir});
      else m_ovf = 1;
      if (m_instrs < 64'hFFFF_FFFF) m_instrs++;
      if (m_pcf == m_last) begin
        if (m_same >= HALT_CNT - 1) m_halted = 1;
        m_same = (m_same + 1 > HALT_CNT) ? HALT_CNT : m_same + 1;
      end else begin
        m_same = 0;
      end
      m_last = m_pcf;
    end
    if (int'(q) == FS) m_pcf = pc;
    m_qprev = int'(q);
  endtask

  task automatic compare_all();
    check("count",    64'(count),    64'(m_fifo.size()));
    check("empty",    64'(empty),    64'(m_fifo.size() == 0));
    check("full",     64'(full),     64'(m_fifo.size() == DEPTH));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("cycles",   64'(cycles),   64'(m_cycles));
    check("instrs",   64'(instrs),   64'(m_instrs));
    check("halted",   64'(halted),   64'(m_halted));
    check("rd_valid", 64'(rd_valid), 64'(m_rdv));
    check("rd_pc",    64'(rd_pc),    64'(m_rdpc));
    check("rd_ir",    64'(rd_ir),    64'(m_rdir));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cyc(input int qi, input logic [31:0] pci, input logic [31:0] iri,
                     input logic eni, input logic rdi);
    q = STATE_W'(qi); pc = pci; ir = iri; en = eni; rd_en = rdi;
    model_step();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1; q = '0; en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    clr = 1'b0;
  endtask

  // Fetch cycle then decode cycle, which is the capture event.
  task automatic fetch(input logic [31:0] pcv, input logic [31:0] irv, input logic rdi);
    cyc(0, pcv, 32'h0, 1'b1, 1'b0);
    cyc(1, pcv + 32'd4, irv, 1'b1, rdi);
  endtask

  initial begin
    model_reset();
    // Reset
    do_reset(2);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);

    // Basic trace: states 0,1,2,0,1
    cyc(0, 32'h00, 32'h0,        1'b1, 1'b0);
    cyc(1, 32'h04, 32'h8C010000, 1'b1, 1'b0);
    cyc(2, 32'h04, 32'h8C010000, 1'b1, 1'b0);
    cyc(0, 32'h04, 32'h8C010000, 1'b1, 1'b0);
    cyc(1, 32'h08, 32'h00221820, 1'b1, 1'b0);
    check("basic_count", 64'(count), 64'd2);
    cyc(2, 32'h08, 32'h00221820, 1'b1, 1'b1);
    check("basic_pop0", {rd_pc, rd_ir}, {32'h00, 32'h8C010000});
    cyc(2, 32'h08, 32'h00221820, 1'b1, 1'b1);
    check("basic_pop1", {rd_pc, rd_ir}, {32'h04, 32'h00221820});
    check("basic_instrs", 64'(instrs), 64'd2);
    cyc(2, 32'h08, 32'h00221820, 1'b1, 1'b1);   // pop while empty
    check("empty_pop_vld", 64'(rd_valid), 64'd0);

    // Full / overflow
    do_reset(1);
    for (int i = 0; i < 6; i++) fetch(32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 1'b0);
    check("ovf_full",   64'(full),     64'd1);
    check("ovf_flag",   64'(overflow), 64'd1);
    check("ovf_instrs", 64'(instrs),   64'd6);
    // Simultaneous pop and push at full
    fetch(32'h200, 32'hBEEF, 1'b1);
    check("pushpop_count", 64'(count), 64'd4);
    check("pushpop_pc0",   64'(rd_pc), 64'h100);
    for (int i = 0; i < 4; i++) cyc(2, 32'h0, 32'h0, 1'b1, 1'b1);
    check("pushpop_last",  64'(rd_pc), 64'h200);

    // Halt on 4th identical capture at 0x20
    do_reset(1);
    for (int i = 0; i < 3; i++) fetch(32'h20, 32'h08000008, 1'b1);
    check("halt_not_yet", 64'(halted), 64'd0);
    fetch(32'h20, 32'h08000008, 1'b1);
    check("halt_set", 64'(halted), 64'd1);
    for (int i = 0; i < 3; i++) fetch(32'h20, 32'h08000008, 1'b1);
    check("halt_instrs", 64'(instrs), 64'd4);
    do_reset(1);
    check("halt_cleared", 64'(halted), 64'd0);

    // en low across two fetches
    fetch(32'h40, 32'h1, 1'b0);
    cyc(0, 32'h44, 32'h0, 1'b0, 1'b0);
    cyc(1, 32'h48, 32'h2, 1'b0, 1'b0);
    cyc(0, 32'h48, 32'h0, 1'b0, 1'b0);
    cyc(1, 32'h4C, 32'h3, 1'b0, 1'b0);
    check("en_low_instrs", 64'(instrs), 64'd1);

    // clr mid-trace with 3 entries, effect without waiting for a clock edge
    fetch(32'h50, 32'h5, 1'b0);
    fetch(32'h54, 32'h6, 1'b0);
    check("pre_clr_count", 64'(count), 64'd3);
    clr = 1'b1;
    #1;
    check("clr_async_count", 64'(count), 64'd0);
    check("clr_async_empty", 64'(empty), 64'd1);
    do_reset(1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int          qi;
      logic [31:0] pcr;
      qi  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
      pcr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h20 + 32'(4 * $urandom_range(0, 1));
      cyc(qi, pcr, $urandom, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 99) == 0) do_reset(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
